// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Merges the ID hazard, SRAM wait states, the multi-cycle divider and MEM-stage
// exception/ERET redirects into per-register stall and flush strobes.
// It also owns the divider occupancy counter and the data-access timeout counter.
//
// state  | meaning
// -------+-------------------------------------------------------------
// ST_RUN | no divide in flight; a DIV reaching EX is accepted here
// ST_DIV | divide in flight; div_cnt_q counts down the remaining cycles
module pipe_stall_ctrl #(
    parameter int DIV_LAT     = 36,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic conflict_stall_i,
    input  logic inst_req_i,
    input  logic inst_ok_i,
    input  logic data_req_mem_i,
    input  logic data_ok_i,
    input  logic div_req_ex_i,
    input  logic exc_mem_i,
    input  logic eret_mem_i,
    output logic stall_pc_o,
    output logic stall_if_id_o,
    output logic stall_id_ex_o,
    output logic stall_ex_mem_o,
    output logic flush_if_id_o,
    output logic flush_id_ex_o,
    output logic flush_ex_mem_o,
    output logic flush_mem_wb_o,
    output logic exc_redirect_o,
    output logic div_busy_o,
    output logic div_done_o,
    output logic div_abort_o,
    output logic mem_timeout_o
);

    localparam int DCW = $clog2(DIV_LAT);
    localparam int TCW = $clog2(MEM_TIMEOUT + 1);

    // The entry cycle is spent in ST_RUN and the final cycle at count zero,
    // so the counter is loaded two short of the full latency.
    localparam logic [DCW-1:0] DIV_INIT = DCW'(DIV_LAT - 2);
    localparam logic [TCW-1:0] TO_LAST  = TCW'(MEM_TIMEOUT - 1);

    typedef enum logic {ST_RUN = 1'b0, ST_DIV = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [DCW-1:0] div_cnt_q, div_cnt_d;
    logic [TCW-1:0] to_cnt_q, to_cnt_d;

    logic exc, dwait, iwait, divw, div_cnt_zero;

    assign exc          = exc_mem_i | eret_mem_i;
    assign dwait        = data_req_mem_i & ~data_ok_i;
    assign iwait        = inst_req_i & ~inst_ok_i;
    assign div_cnt_zero = (div_cnt_q == '0);
    assign divw         = (state_q == ST_RUN) ? div_req_ex_i : ~div_cnt_zero;

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_RUN;
            div_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    // Next state: divider sequencing and data-wait timeout counting.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        to_cnt_d  = '0;
        if (exc) begin
            state_d   = ST_RUN;
            div_cnt_d = '0;
        end else begin
            if (dwait) begin
                to_cnt_d = (to_cnt_q == TO_LAST) ? '0 : to_cnt_q + 1'b1;
            end
            case (state_q)
                ST_RUN: begin
                    if (div_req_ex_i && !dwait) begin
                        state_d   = ST_DIV;
                        div_cnt_d = DIV_INIT;
                    end
                end
                ST_DIV: begin
                    // The count keeps running under a data wait; only the
                    // completion itself has to wait for MEM to drain.
                    if (!div_cnt_zero) begin
                        div_cnt_d = div_cnt_q - 1'b1;
                    end else if (!dwait) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Outputs: reset and exceptions override, otherwise the deepest cause wins.
    always_comb begin
        stall_pc_o     = 1'b0;
        stall_if_id_o  = 1'b0;
        stall_id_ex_o  = 1'b0;
        stall_ex_mem_o = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        flush_ex_mem_o = 1'b0;
        flush_mem_wb_o = 1'b0;
        exc_redirect_o = 1'b0;
        div_done_o     = 1'b0;
        div_abort_o    = 1'b0;
        mem_timeout_o  = 1'b0;
        div_busy_o     = (state_q == ST_DIV);
        if (rst_i || exc) begin
            flush_if_id_o  = 1'b1;
            flush_id_ex_o  = 1'b1;
            flush_ex_mem_o = 1'b1;
            flush_mem_wb_o = 1'b1;
            if (!rst_i) begin
                exc_redirect_o = 1'b1;
                div_abort_o    = (state_q == ST_DIV);
            end
        end else begin
            div_done_o    = (state_q == ST_DIV) && div_cnt_zero && !dwait;
            mem_timeout_o = dwait && (to_cnt_q == TO_LAST);
            if (dwait) begin
                stall_pc_o     = 1'b1;
                stall_if_id_o  = 1'b1;
                stall_id_ex_o  = 1'b1;
                stall_ex_mem_o = 1'b1;
                flush_mem_wb_o = 1'b1;
            end else if (divw) begin
                stall_pc_o     = 1'b1;
                stall_if_id_o  = 1'b1;
                stall_id_ex_o  = 1'b1;
                flush_ex_mem_o = 1'b1;
            end else if (conflict_stall_i) begin
                stall_pc_o     = 1'b1;
                stall_if_id_o  = 1'b1;
                flush_id_ex_o  = 1'b1;
            end else if (iwait) begin
                stall_pc_o     = 1'b1;
                flush_if_id_o  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed scenarios with literal expectations plus a
// per-cycle comparison of every output against a behavioural model.
module tb_pipe_stall_ctrl;

    localparam int DIV_LAT = 36;
    localparam int MT      = 4;

    logic clk = 1'b0;
    logic rst, conflict_stall, inst_req, inst_ok, data_req_mem, data_ok;
    logic div_req_ex, exc_mem, eret_mem;
    logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
    logic exc_redirect, div_busy, div_done, div_abort, mem_timeout;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.DIV_LAT(DIV_LAT), .MEM_TIMEOUT(MT)) dut (
        .clk_i(clk), .rst_i(rst),
        .conflict_stall_i(conflict_stall), .inst_req_i(inst_req), .inst_ok_i(inst_ok),
        .data_req_mem_i(data_req_mem), .data_ok_i(data_ok), .div_req_ex_i(div_req_ex),
        .exc_mem_i(exc_mem), .eret_mem_i(eret_mem),
        .stall_pc_o(stall_pc), .stall_if_id_o(stall_if_id), .stall_id_ex_o(stall_id_ex),
        .stall_ex_mem_o(stall_ex_mem), .flush_if_id_o(flush_if_id), .flush_id_ex_o(flush_id_ex),
        .flush_ex_mem_o(flush_ex_mem), .flush_mem_wb_o(flush_mem_wb),
        .exc_redirect_o(exc_redirect), .div_busy_o(div_busy), .div_done_o(div_done),
        .div_abort_o(div_abort), .mem_timeout_o(mem_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        conflict_stall = 0; inst_req = 0; inst_ok = 0; data_req_mem = 0; data_ok = 0;
        div_req_ex = 0; exc_mem = 0; eret_mem = 0;
    endtask

    // Behavioural model: a divide occupies EX for DIV_LAT cycles counted from
    // entry; timeouts fall on every MT-th cycle of an unbroken data-wait run.
    bit in_div = 0;
    int age    = 0;
    int run    = 0;

    initial begin
        logic [12:0] exp_v, act_v;
        bit dw, iw, ex, fin, divw;
        int d;
        @(posedge clk);
        forever begin
            @(negedge clk);
            dw   = data_req_mem & ~data_ok;
            iw   = inst_req & ~inst_ok;
            ex   = exc_mem | eret_mem;
            fin  = in_div && (age >= DIV_LAT - 1);
            divw = in_div ? !fin : div_req_ex;
            // {stall pc,if_id,id_ex,ex_mem, flush if_id,id_ex,ex_mem,mem_wb,
            //  redirect, busy, done, abort, timeout}
            exp_v = '0;
            exp_v[3] = in_div;
            if (rst) begin
                exp_v[8:5] = 4'b1111;
            end else if (ex) begin
                exp_v[8:5] = 4'b1111;
                exp_v[4]   = 1'b1;
                exp_v[1]   = in_div;
            end else begin
                d = dw ? 4 : divw ? 3 : conflict_stall ? 2 : iw ? 1 : 0;
                exp_v[12] = (d >= 1);
                exp_v[11] = (d > 1);
                exp_v[10] = (d > 2);
                exp_v[9]  = (d > 3);
                exp_v[8]  = (d == 1);
                exp_v[7]  = (d == 2);
                exp_v[6]  = (d == 3);
                exp_v[5]  = (d == 4);
                exp_v[2]  = fin && !dw;
                exp_v[0]  = dw && ((run + 1) % MT == 0);
            end
            act_v = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                     flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
                     exc_redirect, div_busy, div_done, div_abort, mem_timeout};
            chk("model_cmp", 32'(act_v), 32'(exp_v));
            if (rst || ex) begin
                in_div = 0; age = 0; run = 0;
            end else begin
                run = dw ? run + 1 : 0;
                if (!in_div) begin
                    if (div_req_ex && !dw) begin in_div = 1; age = 1; end
                end else if (fin && !dw) begin
                    in_div = 0;
                end else if (age < DIV_LAT - 1) begin
                    age++;
                end
            end
        end
    end

    initial begin
        int n_stall, n_busy, done_at, n_done;
        logic [8:0] to_mask;
        idle();
        rst = 1;
        step(); step();
        #2;
        chk("reset_outputs",
            32'({stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex,
                 flush_ex_mem, flush_mem_wb, exc_redirect, div_done, div_abort, mem_timeout, div_busy}),
            32'(13'b0000_1111_00000));

        // T1 load-use
        step(); rst = 0; idle(); conflict_stall = 1; #2;
        chk("t1_stalls",  32'({stall_pc, stall_if_id, stall_id_ex, stall_ex_mem}), 32'(4'b1100));
        chk("t1_flushes", 32'({flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb}), 32'(4'b0100));
        step(); idle(); #2;
        chk("t1_release", 32'({stall_pc, stall_if_id, flush_id_ex}), 32'(3'b000));

        // T2 full divide with div_req_ex held
        n_stall = 0; n_busy = 0; done_at = 0;
        for (int i = 1; i <= 36; i++) begin
            step(); div_req_ex = 1; #2;
            n_stall += int'(stall_id_ex);
            n_busy  += int'(div_busy);
            if (div_done && done_at == 0) done_at = i;
        end
        chk("t2_stall_cycles", n_stall, 35);
        chk("t2_busy_cycles",  n_busy, 35);
        chk("t2_done_cycle",   done_at, 36);

        // back-to-back DIV re-enters, then T4 exception at its cycle 10
        step(); div_req_ex = 1; #2;
        chk("b2b_reentry", 32'({stall_id_ex, div_busy}), 32'(2'b10));
        for (int k = 2; k <= 9; k++) begin step(); idle(); end
        step(); exc_mem = 1; conflict_stall = 1; inst_req = 1; #2;
        chk("t4_stalls",  32'({stall_pc, stall_if_id, stall_id_ex, stall_ex_mem}), 32'(4'b0000));
        chk("t4_flushes", 32'({flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb}), 32'(4'b1111));
        chk("t4_pulses",  32'({exc_redirect, div_abort, div_done}), 32'(3'b110));
        step(); idle(); #2;
        chk("t4_back_to_run", 32'(div_busy), 32'(1'b0));

        // T3 data wait during the tail of a divide delays completion
        step(); div_req_ex = 1;
        for (int k = 2; k <= 38; k++) begin
            step(); idle(); data_req_mem = (k >= 35 && k <= 37); #2;
            if (k == 35) chk("t3_dwait_wins", 32'({stall_ex_mem, flush_mem_wb, flush_ex_mem}), 32'(3'b110));
            if (k == 36) chk("t3_done_held", 32'(div_done), 32'(1'b0));
            if (k == 37) chk("t3_still_busy", 32'({div_busy, div_done}), 32'(2'b10));
            if (k == 38) chk("t3_done_late", 32'({div_busy, div_done}), 32'(2'b11));
        end

        // T5 timeout pulses every 4th wait cycle
        step(); idle();
        n_stall = 0; to_mask = '0;
        for (int k = 1; k <= 9; k++) begin
            step(); data_req_mem = 1; #2;
            to_mask[k-1] = mem_timeout;
            n_stall += int'(stall_ex_mem);
        end
        chk("t5_timeout_cycles", 32'(to_mask), 32'(9'b010001000));
        chk("t5_stall_held", n_stall, 9);

        // T6 reset in the middle of a divide
        step(); idle(); div_req_ex = 1;
        for (int k = 2; k <= 4; k++) begin step(); idle(); end
        step(); rst = 1; #2;
        chk("t6_rst_outputs",
            32'({stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex,
                 flush_ex_mem, flush_mem_wb, exc_redirect, div_done, div_abort, mem_timeout, div_busy}),
            32'(13'b0000_1111_00001));
        step(); #2;
        chk("t6_busy_cleared", 32'(div_busy), 32'(1'b0));
        step(); rst = 0;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin step(); #2; n_done += int'(div_done); end
        chk("t6_no_done", n_done, 0);

        // mixed traffic, checked by the model only
        for (int k = 0; k < 400; k++) begin
            step();
            conflict_stall = ($urandom_range(0, 3) == 0);
            inst_req       = $urandom_range(0, 1) == 1;
            inst_ok        = $urandom_range(0, 1) == 1;
            data_req_mem   = $urandom_range(0, 1) == 1;
            data_ok        = ($urandom_range(0, 2) == 0);
            div_req_ex     = ($urandom_range(0, 3) != 0);
            exc_mem        = ($urandom_range(0, 40) == 0);
            eret_mem       = ($urandom_range(0, 60) == 0);
        end
        step(); idle();
        step();
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
